// File: rtl/accumulator_sequencer.sv
// Accumulator register with a built-in repeat sequencer: one start pulse applies
// a latched operation (load/add/sub/shift/rotate/clear/hold) for a programmed number of cycles.
module accumulator_sequencer #(
    parameter int N   = 64,
    parameter int RW  = 8,
    parameter bit SAT = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [2:0]    op,
    input  logic [RW-1:0] rep_count,
    input  logic [N-1:0]  load_val,
    input  logic [N-1:0]  step_val,
    input  logic          serial_in,
    output logic [N-1:0]  acc,
    output logic          carry,
    output logic          ovf,
    output logic          zero,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [2:0] OP_HOLD  = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_SHL   = 3'b100;
    localparam logic [2:0] OP_SHR   = 3'b101;
    localparam logic [2:0] OP_ROTL  = 3'b110;
    localparam logic [2:0] OP_CLEAR = 3'b111;

    state_t          state_reg, state_next;
    logic [N-1:0]    acc_reg, acc_next;
    logic            carry_reg, carry_next;
    logic            ovf_reg, ovf_next;
    logic [RW-1:0]   remaining_reg, remaining_next;
    logic [2:0]      op_reg, op_next;
    logic [N-1:0]    step_reg, step_next;
    logic [N-1:0]    load_reg, load_next;
    logic            sin_reg, sin_next;

    // N+1 bit results: the top bit is the carry out of ADD or the borrow of SUB.
    logic [N:0]      sum;
    logic [N:0]      diff;

    assign sum  = {1'b0, acc_reg} + {1'b0, step_reg};
    assign diff = {1'b0, acc_reg} - {1'b0, step_reg};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            carry_reg     <= 1'b0;
            ovf_reg       <= 1'b0;
            remaining_reg <= '0;
            op_reg        <= OP_HOLD;
            step_reg      <= '0;
            load_reg      <= '0;
            sin_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            carry_reg     <= carry_next;
            ovf_reg       <= ovf_next;
            remaining_reg <= remaining_next;
            op_reg        <= op_next;
            step_reg      <= step_next;
            load_reg      <= load_next;
            sin_reg       <= sin_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        carry_next     = carry_reg;
        ovf_next       = ovf_reg;
        remaining_next = remaining_reg;
        op_next        = op_reg;
        step_next      = step_reg;
        load_next      = load_reg;
        sin_next       = sin_reg;
        busy           = 1'b0;
        done           = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    op_next        = op;
                    step_next      = step_val;
                    load_next      = load_val;
                    sin_next       = serial_in;
                    remaining_next = (rep_count == '0) ? RW'(1) : rep_count;
                    state_next     = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                // Abort wins over the op: the aborting edge leaves acc/carry/ovf untouched.
                if (abort) begin
                    state_next = IDLE;
                end else begin
                    case (op_reg)
                        OP_LOAD: begin
                            acc_next   = load_reg;
                            carry_next = 1'b0;
                            ovf_next   = 1'b0;
                        end
                        OP_ADD: begin
                            acc_next   = (SAT && sum[N]) ? {N{1'b1}} : sum[N-1:0];
                            carry_next = sum[N];
                            ovf_next   = ovf_reg | sum[N];
                        end
                        OP_SUB: begin
                            acc_next   = (SAT && diff[N]) ? {N{1'b0}} : diff[N-1:0];
                            carry_next = diff[N];
                            ovf_next   = ovf_reg | diff[N];
                        end
                        OP_SHL: begin
                            acc_next   = {acc_reg[N-2:0], sin_reg};
                            carry_next = acc_reg[N-1];
                        end
                        OP_SHR: begin
                            acc_next   = {sin_reg, acc_reg[N-1:1]};
                            carry_next = acc_reg[0];
                        end
                        OP_ROTL: begin
                            acc_next   = {acc_reg[N-2:0], acc_reg[N-1]};
                            carry_next = acc_reg[N-1];
                        end
                        OP_CLEAR: begin
                            acc_next   = '0;
                            carry_next = 1'b0;
                            ovf_next   = 1'b0;
                        end
                        default: ;
                    endcase
                    remaining_next = remaining_reg - RW'(1);
                    if (remaining_reg <= RW'(1)) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign acc   = acc_reg;
    assign carry = carry_reg;
    assign ovf   = ovf_reg;
    assign zero  = (acc_reg == '0);

endmodule

// File: tb/tb_accumulator_sequencer.sv
// Directed bench: three instances (64-bit wrap, 8-bit wrap, 8-bit saturating) share one stimulus stream.
module tb_accumulator_sequencer;

    localparam logic [2:0] HOLD = 3'b000, LOAD = 3'b001, ADD = 3'b010, SUB = 3'b011;
    localparam logic [2:0] SHL = 3'b100, SHR = 3'b101, ROTL = 3'b110, CLEAR = 3'b111;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [2:0]  op = HOLD;
    logic [7:0]  rep_count = 8'd0;
    logic [63:0] load_val = 64'd0;
    logic [63:0] step_val = 64'd0;
    logic        serial_in = 1'b0;

    logic [63:0] acc64;
    logic [7:0]  acc8w, acc8s;
    logic        carry64, carry8w, carry8s;
    logic        ovf64, ovf8w, ovf8s;
    logic        zero64, zero8w, zero8s;
    logic        busy64, busy8w, busy8s;
    logic        done64, done8w, done8s;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    accumulator_sequencer #(.N(64), .RW(8), .SAT(1'b0)) u64 (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .op(op),
        .rep_count(rep_count), .load_val(load_val), .step_val(step_val),
        .serial_in(serial_in), .acc(acc64), .carry(carry64), .ovf(ovf64),
        .zero(zero64), .busy(busy64), .done(done64));

    accumulator_sequencer #(.N(8), .RW(8), .SAT(1'b0)) u8w (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .op(op),
        .rep_count(rep_count), .load_val(load_val[7:0]), .step_val(step_val[7:0]),
        .serial_in(serial_in), .acc(acc8w), .carry(carry8w), .ovf(ovf8w),
        .zero(zero8w), .busy(busy8w), .done(done8w));

    accumulator_sequencer #(.N(8), .RW(8), .SAT(1'b1)) u8s (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .op(op),
        .rep_count(rep_count), .load_val(load_val[7:0]), .step_val(step_val[7:0]),
        .serial_in(serial_in), .acc(acc8s), .carry(carry8s), .ovf(ovf8s),
        .zero(zero8s), .busy(busy8s), .done(done8s));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called in IDLE or DONE; returns at the falling edge of the first busy cycle.
    task automatic start_op(input logic [2:0] o, input logic [7:0] rep,
                            input logic [63:0] ld, input logic [63:0] st, input logic si);
        @(negedge clk);
        op = o; rep_count = rep; load_val = ld; step_val = st; serial_in = si;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (done64 !== 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("done_reached", {63'd0, done64}, 64'd1);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_acc", acc64, 64'd0);
        chk("rst_flags", {59'd0, carry64, ovf64, zero64, busy64, done64}, 64'b00100);
        @(negedge clk);
        reset = 1'b1;

        // 1: LOAD 0, ADD 10 x5 on the 64-bit instance
        start_op(LOAD, 8'd1, 64'd0, 64'd0, 1'b0);
        wait_done();
        start_op(ADD, 8'd5, 64'd0, 64'd10, 1'b0);
        chk("t1_busy0", {63'd0, busy64}, 64'd1);
        chk("t1_acc0", acc64, 64'd0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            $display("t1 cycle %0d acc=%0d busy=%0b done=%0b", k, acc64, busy64, done64);
            chk("t1_acc", acc64, 64'(10 * k));
            chk("t1_busy", {63'd0, busy64}, (k < 5) ? 64'd1 : 64'd0);
            chk("t1_done", {63'd0, done64}, (k == 5) ? 64'd1 : 64'd0);
        end

        // 2: 8-bit wrap overflow, then ovf stays sticky
        start_op(LOAD, 8'd1, 64'd250, 64'd0, 1'b0);
        wait_done();
        start_op(ADD, 8'd1, 64'd0, 64'd10, 1'b0);
        wait_done();
        $display("t2 add10 acc8w=%0d carry=%0b ovf=%0b acc8s=%0d", acc8w, carry8w, ovf8w, acc8s);
        chk("t2_acc8w", {56'd0, acc8w}, 64'd4);
        chk("t2_c_o_8w", {62'd0, carry8w, ovf8w}, 64'b11);
        chk("t2_acc8s_sat", {56'd0, acc8s}, 64'd255);
        chk("t2_acc64", acc64, 64'd260);
        start_op(ADD, 8'd1, 64'd0, 64'd1, 1'b0);
        wait_done();
        $display("t2 add1 acc8w=%0d carry=%0b ovf=%0b", acc8w, carry8w, ovf8w);
        chk("t2b_acc8w", {56'd0, acc8w}, 64'd5);
        chk("t2b_c_o_8w", {62'd0, carry8w, ovf8w}, 64'b01);

        // 3: saturating SUB clamps at 0; CLEAR and LOAD clear ovf
        start_op(LOAD, 8'd1, 64'd5, 64'd0, 1'b0);
        wait_done();
        start_op(SUB, 8'd1, 64'd0, 64'd9, 1'b0);
        wait_done();
        $display("t3 sub9 acc8s=%0d carry=%0b ovf=%0b acc8w=%0d", acc8s, carry8s, ovf8s, acc8w);
        chk("t3_acc8s", {56'd0, acc8s}, 64'd0);
        chk("t3_c_o_8s", {62'd0, carry8s, ovf8s}, 64'b11);
        chk("t3_acc8w", {56'd0, acc8w}, 64'd252);
        start_op(CLEAR, 8'd1, 64'd0, 64'd0, 1'b0);
        wait_done();
        chk("t3_clear8w", {54'd0, acc8w, carry8w, ovf8w}, 64'd0);
        start_op(LOAD, 8'd1, 64'd0, 64'd0, 1'b0);
        wait_done();
        $display("t3 load0 ovf8s=%0b zero8s=%0b", ovf8s, zero8s);
        chk("t3_ovf_zero8s", {62'd0, ovf8s, zero8s}, 64'b01);

        // 4: SHL with serial_in=1, ROTL x8, SHR
        start_op(LOAD, 8'd1, 64'h81, 64'd0, 1'b0);
        wait_done();
        start_op(SHL, 8'd2, 64'd0, 64'd0, 1'b1);
        @(negedge clk);
        $display("t4 shl1 acc8w=%0h carry=%0b", acc8w, carry8w);
        chk("t4_shl1", {55'd0, acc8w, carry8w}, {55'd0, 8'h03, 1'b1});
        @(negedge clk);
        $display("t4 shl2 acc8w=%0h carry=%0b done=%0b", acc8w, carry8w, done8w);
        chk("t4_shl2", {55'd0, acc8w, carry8w}, {55'd0, 8'h07, 1'b0});
        chk("t4_shl_done", {63'd0, done8w}, 64'd1);
        start_op(LOAD, 8'd1, 64'h81, 64'd0, 1'b0);
        wait_done();
        start_op(ROTL, 8'd8, 64'd0, 64'd0, 1'b0);
        @(negedge clk);
        chk("t4_rotl1", {56'd0, acc8w}, 64'h03);
        wait_done();
        $display("t4 rotl8 acc8w=%0h carry=%0b", acc8w, carry8w);
        chk("t4_rotl8", {55'd0, acc8w, carry8w}, {55'd0, 8'h81, 1'b1});
        start_op(SHR, 8'd1, 64'd0, 64'd0, 1'b0);
        wait_done();
        chk("t4_shr", {55'd0, acc8w, carry8w}, {55'd0, 8'h40, 1'b1});

        // 5: ADD x10 aborted on third busy cycle; start during busy ignored
        start_op(LOAD, 8'd1, 64'd0, 64'd0, 1'b0);
        wait_done();
        start_op(ADD, 8'd10, 64'd0, 64'd10, 1'b0);
        start = 1'b1; op = CLEAR; step_val = 64'd99; rep_count = 8'd1;
        @(negedge clk);
        start = 1'b0;
        chk("t5_acc_b2", {56'd0, acc8w}, 64'd10);
        @(negedge clk);
        chk("t5_acc_b3", {56'd0, acc8w}, 64'd20);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        $display("t5 abort acc8w=%0d busy=%0b done=%0b", acc8w, busy8w, done8w);
        chk("t5_acc_abort", {56'd0, acc8w}, 64'd20);
        chk("t5_busy_done", {62'd0, busy8w, done8w}, 64'b00);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t5_no_done", {62'd0, busy8w, done8w}, 64'b00);
        end

        // 6: rep_count 0 runs once; async reset mid-run
        start_op(ADD, 8'd0, 64'd0, 64'd1, 1'b0);
        chk("t6_busy", {63'd0, busy8w}, 64'd1);
        @(negedge clk);
        $display("t6 rep0 acc8w=%0d done=%0b", acc8w, done8w);
        chk("t6_rep0", {55'd0, acc8w, done8w}, {55'd0, 8'd21, 1'b1});
        start_op(ADD, 8'd10, 64'd0, 64'd7, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        $display("t6 reset acc64=%0d acc8w=%0d busy=%0b done=%0b", acc64, acc8w, busy64, done64);
        chk("t6_rst_acc", acc64 | {56'd0, acc8w}, 64'd0);
        chk("t6_rst_flags", {59'd0, carry8w, ovf8w, zero8w, busy8w, done8w}, 64'b00100);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t6_post_rst", {62'd0, busy64, done64}, 64'b00);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
